data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_resp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: word-organised data memory behind a CPU data port.
// One request is in flight at a time. An accepted request waits WAIT_CYCLES
// cycles, then completes with a one-cycle ready pulse and an err flag.
// Misaligned, out-of-range and read+write-together requests are rejected
// with no side effects.
`timescale 1ns/1ps

module data_mem_resp #(
  parameter int DEPTH       = 64,  // number of 32-bit words, 1..1024
  parameter int WAIT_CYCLES = 1    // wait cycles added before each response, 0..15
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active low
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [15:0] wr_count
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Merge new data into an old word, lane by lane, under the byte enables.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

  // FSM and transaction registers.
  logic [1:0]  state_q,    state_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [3:0]  be_q,       be_d;
  logic        rd_q,       rd_d;
  logic        wr_q,       wr_d;

  // Output registers.
  logic [31:0] rdata_q,    rdata_d;
  logic        ready_q,    ready_d;
  logic        err_q,      err_d;
  logic        busy_q,     busy_d;
  logic [15:0] wr_count_q, wr_count_d;

  // Storage; deliberately has no reset so contents survive rst.
  logic [31:0] mem_q [DEPTH];

  // Transaction view: live inputs while still in IDLE (needed when
  // WAIT_CYCLES=0 completes straight from IDLE), latched copy otherwise.
  logic        in_idle_s;
  logic        accept_s;
  logic [31:0] txn_addr_s;
  logic [31:0] txn_wdata_s;
  logic [3:0]  txn_be_s;
  logic        txn_rd_s;
  logic        txn_wr_s;
  logic [29:0] idx_s;
  logic [AW-1:0] mem_idx_s;
  logic        misalign_s;
  logic        out_of_range_s;
  logic        conflict_s;
  logic        bad_s;
  logic        enter_done_s;
  logic        wr_commit_s;
  logic        rd_commit_s;

  assign in_idle_s   = (state_q == S_IDLE);
  assign accept_s    = in_idle_s & (mem_read | mem_write);

  assign txn_addr_s  = in_idle_s ? addr      : addr_q;
  assign txn_wdata_s = in_idle_s ? wdata     : wdata_q;
  assign txn_be_s    = in_idle_s ? byte_en   : be_q;
  assign txn_rd_s    = in_idle_s ? mem_read  : rd_q;
  assign txn_wr_s    = in_idle_s ? mem_write : wr_q;

  assign idx_s          = txn_addr_s[31:2];
  assign mem_idx_s      = idx_s[AW-1:0];
  assign misalign_s     = (txn_addr_s[1:0] != 2'b00);
  assign out_of_range_s = (idx_s >= 30'(DEPTH));
  assign conflict_s     = txn_rd_s & txn_wr_s;
  assign bad_s          = misalign_s | out_of_range_s | conflict_s;

  // A legal operation takes effect only on the edge that enters DONE.
  assign wr_commit_s = enter_done_s & ~bad_s & txn_wr_s;
  assign rd_commit_s = enter_done_s & ~bad_s & txn_rd_s;

  // Next-state logic for the IDLE/WAIT/DONE sequencer and request latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    enter_done_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = byte_en;
          rd_d    = mem_read;
          wr_d    = mem_write;
          if (WAIT_CYCLES == 0) begin
            state_d      = S_DONE;
            cnt_d        = 4'd0;
            enter_done_s = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // cnt<=1 rather than ==1 so a corrupted zero count cannot stall.
        if (cnt_q <= 4'd1) begin
          state_d      = S_DONE;
          cnt_d        = 4'd0;
          enter_done_s = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ready_d = enter_done_s;
    err_d   = enter_done_s & bad_s;
    busy_d  = (state_d != S_IDLE);
    if (rd_commit_s) begin
      rdata_d = mem_q[mem_idx_s];
    end else begin
      rdata_d = rdata_q;
    end
    if (wr_commit_s && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Sequencer, request latch and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Byte-lane write into the array on the edge a legal write enters DONE.
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      mem_q[mem_idx_s] <= merge_lanes(mem_q[mem_idx_s], txn_wdata_s, txn_be_s);
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed testbench for data_mem_resp: one DEPTH=64/WAIT_CYCLES=1 instance
// for most scenarios and a WAIT_CYCLES=0 instance for back-to-back traffic.
`timescale 1ns/1ps

module tb_data_mem_resp;

  logic        clk;
  logic        rst;

  logic        mem_read, mem_write;
  logic [3:0]  byte_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;
  logic [15:0] wr_count;

  logic        z_mem_read, z_mem_write;
  logic [3:0]  z_byte_en;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic        z_ready, z_err, z_busy;
  logic [15:0] z_wr_count;

  int errors = 0;
  int checks = 0;

  data_mem_resp #(.DEPTH(64), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .err(err), .busy(busy), .wr_count(wr_count)
  );

  data_mem_resp #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(z_mem_read), .mem_write(z_mem_write),
    .byte_en(z_byte_en), .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata),
    .ready(z_ready), .err(z_err), .busy(z_busy), .wr_count(z_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on dut, then scramble the inputs (they must be ignored
  // outside IDLE) and wait, bounded, for the ready pulse.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     output logic got_err, output int lat);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d; byte_en = be;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'hDEAD_BEEF; wdata = 32'h5A5A_5A5A; byte_en = 4'hF;
    lat = -1;
    got_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready === 1'b1) begin
        lat = i;
        got_err = err;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL txn_timeout addr=%h: ready never seen within 20 cycles", a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; byte_en = 4'h0; addr = 32'd0; wdata = 32'd0;
    z_mem_read = 1'b0; z_mem_write = 1'b0; z_byte_en = 4'h0; z_addr = 32'd0; z_wdata = 32'd0;
    #2;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_read;
    logic e; int lat;
    @(negedge clk);
    mem_write = 1'b1; addr = 32'd84; wdata = 32'd7; byte_en = 4'hF;
    @(negedge clk);
    mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL wr84_wait busy=%b ready=%b exp busy=1 ready=0", busy, ready); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr84_done ready=%b err=%b busy=%b exp 1 0 1", ready, err, busy); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr84_count got=%0d exp=1", wr_count); end
    @(negedge clk);
    checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr84_idle ready=%b busy=%b exp 0 0", ready, busy); end
    txn(1'b1, 1'b0, 32'd84, 32'd0, 4'h0, e, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rd84_latency got=%0d exp=1", lat); end
    checks++; if (e !== 1'b0 || rdata !== 32'h0000_0007) begin errors++; $display("FAIL rd84_data err=%b rdata=%h exp err=0 rdata=00000007", e, rdata); end
  endtask

  task automatic test_byte_lanes;
    logic e; int lat;
    txn(1'b0, 1'b1, 32'd80, 32'h1122_3344, 4'hF, e, lat);
    txn(1'b0, 1'b1, 32'd80, 32'hAABB_CCDD, 4'b0001, e, lat);
    checks++; if (e !== 1'b0 || wr_count !== 16'd3) begin errors++; $display("FAIL lane0_write err=%b wr_count=%0d exp 0 3", e, wr_count); end
    txn(1'b1, 1'b0, 32'd80, 32'd0, 4'h0, e, lat);
    checks++; if (rdata !== 32'h1122_33DD) begin errors++; $display("FAIL lane0_read got=%h exp=112233dd", rdata); end
    txn(1'b0, 1'b1, 32'd80, 32'hFFFF_FFFF, 4'b0000, e, lat);
    checks++; if (e !== 1'b0 || wr_count !== 16'd4) begin errors++; $display("FAIL be0_write err=%b wr_count=%0d exp 0 4", e, wr_count); end
    txn(1'b1, 1'b0, 32'd80, 32'd0, 4'h0, e, lat);
    checks++; if (rdata !== 32'h1122_33DD) begin errors++; $display("FAIL be0_read got=%h exp=112233dd", rdata); end
    txn(1'b0, 1'b1, 32'd80, 32'h00EE_FF00, 4'b0110, e, lat);
    txn(1'b1, 1'b0, 32'd80, 32'd0, 4'h0, e, lat);
    checks++; if (rdata !== 32'h11EE_FFDD || wr_count !== 16'd5) begin errors++; $display("FAIL mid_lanes rdata=%h wr_count=%0d exp 11eeffdd 5", rdata, wr_count); end
  endtask

  task automatic test_errors;
    logic e; int lat;
    txn(1'b0, 1'b1, 32'd0, 32'h0BAD_BEEF, 4'hF, e, lat);
    txn(1'b0, 1'b1, 32'd252, 32'hCAFE_F00D, 4'hF, e, lat);
    txn(1'b1, 1'b0, 32'd252, 32'd0, 4'h0, e, lat);
    checks++; if (e !== 1'b0 || rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_word err=%b rdata=%h exp 0 cafef00d", e, rdata); end
    txn(1'b0, 1'b1, 32'h55, 32'h0000_0077, 4'hF, e, lat);
    checks++; if (e !== 1'b1 || lat !== 1 || wr_count !== 16'd7) begin errors++; $display("FAIL misaligned err=%b lat=%0d wr_count=%0d exp 1 1 7", e, lat, wr_count); end
    txn(1'b0, 1'b1, 32'd256, 32'h1234_5678, 4'hF, e, lat);
    checks++; if (e !== 1'b1 || wr_count !== 16'd7) begin errors++; $display("FAIL out_of_range_wr err=%b wr_count=%0d exp 1 7", e, wr_count); end
    txn(1'b1, 1'b0, 32'd256, 32'd0, 4'h0, e, lat);
    checks++; if (e !== 1'b1 || rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL out_of_range_rd err=%b rdata=%h exp 1 cafef00d", e, rdata); end
    txn(1'b1, 1'b0, 32'd84, 32'd0, 4'h0, e, lat);
    checks++; if (rdata !== 32'h0000_0007) begin errors++; $display("FAIL misaligned_no_write got=%h exp=00000007", rdata); end
    txn(1'b1, 1'b0, 32'd0, 32'd0, 4'h0, e, lat);
    checks++; if (rdata !== 32'h0BAD_BEEF) begin errors++; $display("FAIL oor_no_alias got=%h exp=0badbeef", rdata); end
  endtask

  task automatic test_rw_both;
    logic e; int lat;
    txn(1'b1, 1'b1, 32'd84, 32'h0000_0099, 4'hF, e, lat);
    checks++; if (e !== 1'b1 || wr_count !== 16'd7 || rdata !== 32'h0BAD_BEEF) begin errors++; $display("FAIL rw_both err=%b wr_count=%0d rdata=%h exp 1 7 0badbeef", e, wr_count, rdata); end
    txn(1'b1, 1'b0, 32'd84, 32'd0, 4'h0, e, lat);
    checks++; if (rdata !== 32'h0000_0007) begin errors++; $display("FAIL rw_both_no_write got=%h exp=00000007", rdata); end
  endtask

  task automatic test_reset_abort;
    logic e; int lat; logic saw_ready;
    @(negedge clk);
    mem_write = 1'b1; addr = 32'd84; wdata = 32'd9; byte_en = 4'hF;
    @(negedge clk);
    mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_wait busy=%b exp=1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b0 || wr_count !== 16'd0 || rdata !== 32'd0) begin errors++; $display("FAIL abort_async busy=%b ready=%b wr_count=%0d rdata=%h exp 0 0 0 0", busy, ready, wr_count, rdata); end
    saw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", saw_ready); end
    rst = 1'b1;
    mem_read = 1'b1; addr = 32'd84;
    @(negedge clk);
    mem_read = 1'b0; addr = 32'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_edge_accept busy=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || rdata !== 32'h0000_0007) begin errors++; $display("FAIL abort_no_write ready=%b rdata=%h exp 1 00000007", ready, rdata); end
    @(negedge clk);
    txn(1'b1, 1'b0, 32'd80, 32'd0, 4'h0, e, lat);
    checks++; if (rdata !== 32'h11EE_FFDD || wr_count !== 16'd0) begin errors++; $display("FAIL mem_kept rdata=%h wr_count=%0d exp 11eeffdd 0", rdata, wr_count); end
  endtask

  task automatic test_back_to_back;
    logic exp_pulse;
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      z_mem_write = 1'b1; z_addr = 32'(4 * n); z_wdata = 32'h100 + 32'(n); z_byte_en = 4'hF;
      @(negedge clk);
      exp_pulse = (n % 2 == 0);
      checks++; if (z_ready !== exp_pulse || z_busy !== exp_pulse || z_err !== 1'b0) begin errors++; $display("FAIL b2b_wr n=%0d ready=%b busy=%b err=%b exp %b %b 0", n, z_ready, z_busy, z_err, exp_pulse, exp_pulse); end
    end
    z_mem_write = 1'b0;
    checks++; if (z_wr_count !== 16'd4) begin errors++; $display("FAIL b2b_wr_count got=%0d exp=4", z_wr_count); end
    for (int n = 0; n < 8; n++) begin
      z_mem_read = 1'b1; z_addr = 32'(4 * n);
      @(negedge clk);
      exp_pulse = (n % 2 == 0);
      checks++; if (z_ready !== exp_pulse || z_busy !== exp_pulse || z_rdata !== 32'h100 + 32'(n - (n % 2))) begin errors++; $display("FAIL b2b_rd n=%0d ready=%b busy=%b rdata=%h exp %b %b %h", n, z_ready, z_busy, z_rdata, exp_pulse, exp_pulse, 32'h100 + 32'(n - (n % 2))); end
    end
    z_mem_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_errors();
    test_rw_both();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
